multicycle_controller: RTL and testbench

Multicycle control unit for the RV32I subset core: a Moore FSM that sequences each instruction through fetch, decode, execute, memory and writeback, plus the ALU decoder that drives the `ALUControl` code consumed by the ALU. It sits between the instruction register and the datapath muxes and enables. It is the producer side of the `ALUControl`/`Zero` interface: it generates the operation code and samples `Zero` for branches. Memory accesses use a ready handshake so slow memories stall the FSM.

---
 rtl/multicycle_controller.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle RV32I-subset control FSM plus ALU decoder; memory states stall on mem_ready.
// Optional macro CTRL_ILLEGAL_TRAP_EN adds the TRAP state and the illegal output.
module multicycle_controller (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic       RegWrite,
   output logic [2:0] ALUControl
`ifdef CTRL_ILLEGAL_TRAP_EN
   ,
   output logic       illegal
`endif
);

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXECUTER, EXECUTEI, ALUWB, BEQ, JAL
`ifdef CTRL_ILLEGAL_TRAP_EN
      , TRAP
`endif
   } state_t;

   state_t     state;
   logic [1:0] alu_op;
   logic       pcupdate;
   logic       branch;

   function automatic logic [2:0] alu_decode(input logic [1:0] aop, input logic [2:0] f3,
                                             input logic sub_r);
      logic [2:0] code;
      code = ALU_ADD;
      if (aop == ALUOP_SUB) code = ALU_SUB;
      else if (aop == ALUOP_FUNCT) begin
         case (f3)
            3'b000:  code = sub_r ? ALU_SUB : ALU_ADD;
            3'b010:  code = ALU_SLT;
            3'b110:  code = ALU_OR;
            3'b111:  code = ALU_AND;
            default: code = ALU_ADD;
         endcase
      end
      return code;
   endfunction

`ifdef CTRL_ILLEGAL_TRAP_EN
   logic f3_ok;
   assign f3_ok   = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                    (funct3 == 3'b110) || (funct3 == 3'b111);
   assign illegal = rst_n && (state == TRAP);
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= FETCH;
      end else begin
         case (state)
            FETCH:    if (mem_ready) state <= DECODE;
            DECODE: begin
               case (op)
                  7'b0000011, 7'b0100011: state <= MEMADR;
                  7'b0110011:             state <= EXECUTER;
                  7'b0010011:             state <= EXECUTEI;
                  7'b1100011:             state <= BEQ;
                  7'b1101111:             state <= JAL;
`ifdef CTRL_ILLEGAL_TRAP_EN
                  default:                state <= TRAP;
`else
                  default:                state <= FETCH;
`endif
               endcase
            end
            MEMADR:   state <= op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  if (mem_ready) state <= MEMWB;
            MEMWB:    state <= FETCH;
            MEMWRITE: if (mem_ready) state <= FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
            EXECUTER: state <= (!f3_ok || (funct7b5 && funct3 != 3'b000)) ? TRAP : ALUWB;
            EXECUTEI: state <= f3_ok ? ALUWB : TRAP;
            TRAP:     state <= TRAP;
`else
            EXECUTER: state <= ALUWB;
            EXECUTEI: state <= ALUWB;
`endif
            ALUWB:    state <= FETCH;
            BEQ:      state <= FETCH;
            JAL:      state <= ALUWB;
            default:  state <= FETCH;
         endcase
      end
   end

   always_comb begin
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ImmSrc    = 2'b00;
      RegWrite  = 1'b0;
      alu_op    = ALUOP_ADD;
      pcupdate  = 1'b0;
      branch    = 1'b0;
      case (state)
         FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = mem_ready;
            pcupdate  = mem_ready;
         end
         DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            ImmSrc  = 2'b10;
         end
         MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ImmSrc  = op[5] ? 2'b01 : 2'b00;
         end
         MEMREAD:  AdrSrc = 1'b1;
         MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
         end
         MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
         end
         EXECUTER: begin
            ALUSrcA = 2'b10;
            alu_op  = ALUOP_FUNCT;
         end
         EXECUTEI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            alu_op  = ALUOP_FUNCT;
         end
         ALUWB:    RegWrite = 1'b1;
         BEQ: begin
            ALUSrcA = 2'b10;
            alu_op  = ALUOP_SUB;
            branch  = 1'b1;
         end
         JAL: begin
            ALUSrcA  = 2'b01;
            ALUSrcB  = 2'b10;
            pcupdate = 1'b1;
         end
         default: ;
      endcase
      // In reset the mux selects look like FETCH but every enable is held off.
      if (!rst_n) begin
         AdrSrc    = 1'b0;
         MemWrite  = 1'b0;
         IRWrite   = 1'b0;
         ResultSrc = 2'b10;
         ALUSrcA   = 2'b00;
         ALUSrcB   = 2'b10;
         ImmSrc    = 2'b00;
         RegWrite  = 1'b0;
         alu_op    = ALUOP_ADD;
         pcupdate  = 1'b0;
         branch    = 1'b0;
      end
      PCWrite    = pcupdate | (branch & Zero);
      ALUControl = alu_decode(alu_op, funct3, op[5] & funct7b5);
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus random instructions
// checked per cycle against a phase-sequence model of each instruction class.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       Zero;
   logic       mem_ready;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
`ifdef CTRL_ILLEGAL_TRAP_EN
   logic       illegal;
`endif

   multicycle_controller dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegWrite(RegWrite), .ALUControl(ALUControl)
`ifdef CTRL_ILLEGAL_TRAP_EN
      , .illegal(illegal)
`endif
   );

   always #5 clk = ~clk;

   localparam int P_F = 0, P_D = 1, P_A = 2, P_MR = 3, P_MWB = 4, P_MW = 5,
                  P_ER = 6, P_EI = 7, P_WB = 8, P_B = 9, P_J = 10, P_T = 11;

   int          checks = 0;
   int          fails  = 0;
   int          zero_mode = 2;
   logic        rscript[$];
   int          phq[$];
   logic [15:0] obs_log[0:63];
   logic [31:0] rw_hist, irw_hist, mw_hist, pcw_hist;
   logic        trapped;

   wire [15:0] obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                      ImmSrc, RegWrite, ALUControl};

   function automatic string pname(input int ph);
      case (ph)
         P_F: return "FETCH";   P_D: return "DECODE";   P_A: return "MEMADR";
         P_MR: return "MEMREAD"; P_MWB: return "MEMWB";  P_MW: return "MEMWRITE";
         P_ER: return "EXECUTER"; P_EI: return "EXECUTEI"; P_WB: return "ALUWB";
         P_B: return "BEQ";     P_J: return "JAL";      default: return "TRAP";
      endcase
   endfunction

   function automatic logic [2:0] alu_funct(input logic [6:0] o, input logic [2:0] f3,
                                            input logic f7);
      case (f3)
         3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
         3'b010:  return 3'b101;
         3'b110:  return 3'b011;
         3'b111:  return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   // Expected control word for one cycle, written from the per-state output table.
   function automatic logic [15:0] exp_word(input int ph, input logic rst, input logic rdy,
                                            input logic z, input logic [6:0] o,
                                            input logic [2:0] f3, input logic f7);
      logic pcw, adr, mw, irw, rw;
      logic [1:0] rs, sa, sb, imm;
      logic [2:0] alu;
      int p;
      logic r;
      pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0;
      rs = 0; sa = 0; sb = 0; imm = 0; alu = 3'b000;
      p = rst ? ph : P_F;
      r = rst ? rdy : 1'b0;
      case (p)
         P_F:   begin sb = 2'b10; rs = 2'b10; irw = r; pcw = r; end
         P_D:   begin sa = 2'b01; sb = 2'b01; imm = 2'b10; end
         P_A:   begin sa = 2'b10; sb = 2'b01; imm = o[5] ? 2'b01 : 2'b00; end
         P_MR:  adr = 1;
         P_MWB: begin rs = 2'b01; rw = 1; end
         P_MW:  begin adr = 1; mw = 1; end
         P_ER:  begin sa = 2'b10; alu = alu_funct(o, f3, f7); end
         P_EI:  begin sa = 2'b10; sb = 2'b01; alu = alu_funct(o, f3, f7); end
         P_WB:  rw = 1;
         P_B:   begin sa = 2'b10; alu = 3'b001; pcw = z; end
         P_J:   begin sa = 2'b01; sb = 2'b10; pcw = 1; end
         default: ;
      endcase
      return {pcw, adr, mw, irw, rs, sa, sb, imm, rw, alu};
   endfunction

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         fails++;
         $error("FAIL %s: observed %0h required %0h", tag, o, e);
      end
   endtask

   // Drive one cycle's inputs, check all outputs, then advance to just after the next edge.
   task automatic step(input int ph, input logic rdy, output logic [15:0] o);
      mem_ready = rdy;
      Zero = (zero_mode == 2) ? 1'($urandom_range(0, 1)) : (zero_mode == 1);
      #1;
      chk({"ctl@", pname(ph)}, {16'h0, obs},
          {16'h0, exp_word(ph, rst_n, rdy, Zero, op, funct3, funct7b5)});
`ifdef CTRL_ILLEGAL_TRAP_EN
      chk({"illegal@", pname(ph)}, {31'h0, illegal}, {31'h0, rst_n && (ph == P_T)});
`endif
      o = obs;
      @(posedge clk);
      #1;
   endtask

   function automatic logic next_ready();
      if (rscript.size() > 0) return rscript.pop_front();
      return ($urandom_range(0, 3) != 0);
   endfunction

   // Phase sequence an instruction walks through, from the instruction class alone.
   task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7);
      logic bad_r, bad_i, trap_en;
`ifdef CTRL_ILLEGAL_TRAP_EN
      trap_en = 1'b1;
`else
      trap_en = 1'b0;
`endif
      bad_i = !(f3 == 3'b000 || f3 == 3'b010 || f3 == 3'b110 || f3 == 3'b111);
      bad_r = bad_i || (f7 && f3 != 3'b000);
      phq = '{P_F, P_D};
      case (o)
         7'b0000011: phq = {phq, P_A, P_MR, P_MWB};
         7'b0100011: phq = {phq, P_A, P_MW};
         7'b0110011: phq = (trap_en && bad_r) ? {phq, P_ER, P_T, P_T, P_T} : {phq, P_ER, P_WB};
         7'b0010011: phq = (trap_en && bad_i) ? {phq, P_EI, P_T, P_T, P_T} : {phq, P_EI, P_WB};
         7'b1100011: phq = {phq, P_B};
         7'b1101111: phq = {phq, P_J, P_WB};
         default:    if (trap_en) phq = {phq, P_T, P_T, P_T};
      endcase
   endtask

   task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
      int idx, cyc, ph;
      logic rdy;
      logic [15:0] w;
      op = o; funct3 = f3; funct7b5 = f7;
      build(o, f3, f7);
      idx = 0; cyc = 0;
      rw_hist = 0; irw_hist = 0; mw_hist = 0; pcw_hist = 0;
      trapped = (phq[phq.size()-1] == P_T);
      while (idx < phq.size()) begin
         if (cyc >= 200) begin
            chk("cycle_budget", cyc, 200 - 1);
            break;
         end
         ph  = phq[idx];
         rdy = next_ready();
         step(ph, rdy, w);
         if (cyc < 64) obs_log[cyc] = w;
         if (cyc < 32) begin
            pcw_hist[cyc] = w[15]; mw_hist[cyc] = w[13];
            irw_hist[cyc] = w[12]; rw_hist[cyc] = w[3];
         end
         if (!((ph == P_F || ph == P_MR || ph == P_MW) && !rdy)) idx++;
         cyc++;
      end
   endtask

   task automatic do_reset();
      logic [15:0] w;
      rst_n = 1'b0;
      step(P_F, 1'($urandom_range(0, 1)), w);
      step(P_F, 1'($urandom_range(0, 1)), w);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [15:0] w;
      logic [6:0]  ops[7];
      logic [6:0]  ro;
      rst_n = 1'b0; op = 7'h0; funct3 = 3'h0; funct7b5 = 1'b0; Zero = 1'b0; mem_ready = 1'b1;
      @(posedge clk);
      #1;
      step(P_F, 1'b1, w);
      chk("reset_irwrite", {31'h0, w[12]}, 32'h0);
      step(P_F, 1'b1, w);
      rst_n = 1'b1;

      // Reset landing in the middle of a stalled store.
      op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
      step(P_F, 1'b1, w);
      step(P_D, 1'b0, w);
      step(P_A, 1'b0, w);
      step(P_MW, 1'b0, w);
      chk("sw_wait_memwrite", {31'h0, w[13]}, 32'h1);
      rst_n = 1'b0;
      step(P_MW, 1'b0, w);
      chk("reset_kills_memwrite", {31'h0, w[13]}, 32'h0);
      step(P_MW, 1'b0, w);
      rst_n = 1'b1;
      step(P_F, 1'b0, w);
      chk("post_reset_irwrite0", {31'h0, w[12]}, 32'h0);
      step(P_F, 1'b1, w);
      chk("post_reset_irwrite1", {31'h0, w[12]}, 32'h1);
      step(P_D, 1'b1, w);
      step(P_A, 1'b1, w);
      step(P_MW, 1'b1, w);

      // R-type sub with no wait states.
      rscript = '{1, 1, 1, 1};
      run_instr(7'b0110011, 3'b000, 1'b1);
      chk("sub_alucontrol", {29'h0, obs_log[2][2:0]}, 32'h1);
      chk("sub_regwrite_cycle", rw_hist, 32'h8);

      // beq taken then not taken.
      zero_mode = 1; rscript = '{1, 1, 1};
      run_instr(7'b1100011, 3'b000, 1'b0);
      chk("beq_taken_pcwrite", pcw_hist, 32'h5);
      zero_mode = 0; rscript = '{1, 1, 1};
      run_instr(7'b1100011, 3'b000, 1'b0);
      chk("beq_not_taken_pcwrite", pcw_hist, 32'h1);
      zero_mode = 2;
      rscript = '{1};
      op = 7'b0010011;
      step(P_F, next_ready(), w);
      chk("beq_then_fetch", {31'h0, w[12]}, 32'h1);
      step(P_D, 1'b1, w);
      step(P_EI, 1'b1, w);
      step(P_WB, 1'b1, w);

      // lw with 3 fetch stalls and 2 read stalls.
      rscript = '{0, 0, 0, 1, 1, 1, 0, 0, 1, 1};
      run_instr(7'b0000011, 3'b010, 1'b0);
      chk("lw_regwrite_cycle", rw_hist, 32'h200);
      chk("lw_resultsrc", {30'h0, obs_log[9][11:10]}, 32'h1);
      chk("lw_irwrite_pulse", irw_hist, 32'h8);

      // I-type ALU decode.
      rscript = '{1, 1, 1, 1};
      run_instr(7'b0010011, 3'b110, 1'b0);
      chk("ori_alucontrol", {29'h0, obs_log[2][2:0]}, 32'h3);
      rscript = '{1, 1, 1, 1};
      run_instr(7'b0010011, 3'b010, 1'b0);
      chk("slti_alucontrol", {29'h0, obs_log[2][2:0]}, 32'h5);
      rscript = '{1, 1, 1, 1};
      run_instr(7'b0010011, 3'b111, 1'b1);
      chk("andi_alucontrol", {29'h0, obs_log[2][2:0]}, 32'h2);

      // jal
      rscript = '{1, 1, 1, 1};
      run_instr(7'b1101111, 3'b000, 1'b0);
      chk("jal_writes", {pcw_hist[3:0], rw_hist[3:0]}, {24'h0, 4'b0101, 4'b1000});

      // Unsupported opcode.
      rscript = '{1, 1, 1, 1, 1};
      run_instr(7'b1111111, 3'b000, 1'b0);
      chk("bad_op_no_writes", rw_hist | mw_hist, 32'h0);
      if (trapped) do_reset();
      rscript = '{1};
      run_instr(7'b0110011, 3'b111, 1'b0);

      // Random instruction mix.
      ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b0};
      for (int i = 0; i < 60; i++) begin
         ro = ops[$urandom_range(0, 6)];
         if (ro == 7'b0) ro = 7'($urandom_range(0, 127));
         run_instr(ro, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         if (trapped) do_reset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
